// File: rtl/trem_pkg.sv
// trem_pkg: shared constants and types for the tremolo stage.
package trem_pkg;
  localparam int DATA_W    = 32;
  localparam int GAIN_BITS = 6;
  localparam int GAIN_MIN  = 32;
  localparam int DIV_BASE  = 126;
  localparam int G_W       = GAIN_BITS + 1;
  localparam int CNT_W     = 10;
  localparam logic [CNT_W-1:0] DIV_R3 = CNT_W'(DIV_BASE);
  localparam logic [CNT_W-1:0] DIV_R2 = CNT_W'(2 * DIV_BASE);
  localparam logic [CNT_W-1:0] DIV_R1 = CNT_W'(4 * DIV_BASE);
  localparam logic [CNT_W-1:0] DIV_R0 = CNT_W'(8 * DIV_BASE);
  typedef enum logic {UP, DOWN} dir_e;
endpackage

// File: rtl/trem_lfo.sv
// trem_lfo: prescaled triangle-wave gain between GAIN_MIN and unity.
module trem_lfo
  import trem_pkg::*;
(
  input  logic           clk_48,
  input  logic           rst_n,
  input  logic [3:0]     options,
  input  logic           hold,
  output logic [G_W-1:0] g
);
  localparam logic [G_W-1:0] G_MAX = G_W'(1 << GAIN_BITS);
  localparam logic [G_W-1:0] G_LO  = G_W'(GAIN_MIN);
  logic [CNT_W-1:0] cnt_q, cnt_d, div;
  logic [G_W-1:0]   g_q, g_d;
  dir_e             dir_q, dir_d;
  logic             step;
  always_comb begin
    div   = options[3] ? DIV_R3 : options[2] ? DIV_R2 : options[1] ? DIV_R1 :
            options[0] ? DIV_R0 : '0;
    step  = (div != '0) && (cnt_q >= div - 1'b1);
    cnt_d = hold ? '0 : (div == '0) ? cnt_q : step ? '0 : cnt_q + 1'b1;
    g_d   = hold ? G_MAX : !step ? g_q : (dir_q == DOWN) ? g_q - 1'b1 : g_q + 1'b1;
    dir_d = hold ? DOWN : (g_d == G_LO) ? UP : (g_d == G_MAX) ? DOWN : dir_q;
  end
  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      g_q   <= G_MAX;
      dir_q <= DOWN;
    end else begin
      cnt_q <= cnt_d;
      g_q   <= g_d;
      dir_q <= dir_d;
    end
  end
  assign g = g_q;
endmodule

// File: rtl/tremolo.sv
// tremolo: scales each sample by the LFO gain, or passes it through when bypassed.
module tremolo
  import trem_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic                 clk_48,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] x,
  input  logic [3:0]           options,
  input  logic [3:0]           en,
  output logic signed [DW-1:0] y
);
  logic [G_W-1:0]        g;
  logic signed [DW+7:0]  xe, ge, prod;
  logic signed [DW-1:0]  y_q, y_d;
  logic                  unused_en;
  assign unused_en = ^{en[3:2], en[0]};
  trem_lfo u_lfo (
    .clk_48  (clk_48),
    .rst_n   (rst_n),
    .options (options),
    .hold    (!en[1]),
    .g       (g)
  );
  // gain is zero-extended so unity (64) stays positive in the signed multiply
  always_comb begin
    xe   = (DW+8)'(x);
    ge   = (DW+8)'({1'b0, g});
    prod = xe * ge;
    y_d  = en[1] ? DW'(prod >>> GAIN_BITS) : x;
  end
  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) y_q <= '0;
    else        y_q <= y_d;
  end
  assign y = y_q;
endmodule

// File: tb/tb_tremolo.sv
// tb_tremolo: directed vectors and timed sequences against hand-computed outputs.
module tb_tremolo;
  logic               clk_48 = 0;
  logic               rst_n  = 0;
  logic signed [31:0] x      = 0;
  logic [3:0]         options = 4'b1000;
  logic [3:0]         en     = 4'b0010;
  logic signed [31:0] y;
  int                 total = 0, passed = 0, cyc = 0;

  typedef struct {
    logic [3:0]         en;
    logic signed [31:0] x;
    logic signed [31:0] y;
  } vec_t;
  vec_t vecs [8];

  tremolo dut (
    .clk_48  (clk_48),
    .rst_n   (rst_n),
    .x       (x),
    .options (options),
    .en      (en),
    .y       (y)
  );

  always #5 clk_48 = ~clk_48;

  task automatic step();
    @(posedge clk_48);
    #1 cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic chk(input string name, input logic signed [31:0] exp);
    total++;
    if (y === exp) passed++;
    else $display("FAIL %s: y=%0d expected %0d", name, y, exp);
  endtask

  // one bypass clock returns the LFO to g=64, then enable restarts the step count
  task automatic restart(input logic [3:0] opt);
    en = 4'b0000;
    step();
    en = 4'b0010;
    options = opt;
    cyc = 0;
  endtask

  initial begin
    vecs[0] = '{4'b0010, -32'sd1000, -32'sd985};
    vecs[1] = '{4'b1111, 32'sd64, 32'sd63};
    vecs[2] = '{4'b1010, -32'sd64, -32'sd63};
    vecs[3] = '{4'b0010, 32'sd0, 32'sd0};
    vecs[4] = '{4'b0011, 32'sh7fffffff, 32'sd2113929215};
    vecs[5] = '{4'b0010, 32'sh80000000, -32'sd2113929216};
    vecs[6] = '{4'b0110, 32'sd1, 32'sd0};
    vecs[7] = '{4'b0010, -32'sd1, -32'sd1};

    x = 1000;
    repeat (3) @(posedge clk_48);
    #1 chk("reset_y", 0);
    rst_n = 1;
    cyc = 0;
    step();
    chk("unity_first", 1000);
    run_to(126);
    chk("pre_step", 1000);
    step();
    chk("first_step_g63", 984);

    for (int i = 0; i < 8; i++) begin
      en = vecs[i].en;
      x  = vecs[i].x;
      step();
      chk($sformatf("vec%0d", i), vecs[i].y);
    end
    en = 4'b0010;
    x = 1000;

    run_to(4033);
    chk("g32_bottom", 500);
    run_to(4158);
    chk("g32_hold", 500);
    step();
    chk("g33_rising", 515);

    en = 4'b0000;
    x = -12345;
    step();
    chk("bypass", -12345);
    en = 4'b0010;
    cyc = 0;
    step();
    chk("reenable_unity", -12345);
    run_to(126);
    chk("reenable_126", -12345);
    step();
    chk("reenable_step_floor", -12153);

    x = 1000;
    restart(4'b0001);
    run_to(1008);
    chk("slow_pre_step", 1000);
    step();
    chk("slow_step", 984);

    options = 4'b0000;
    repeat (5000) step();
    chk("frozen", 984);

    restart(4'b1100);
    run_to(126);
    chk("multi_hot_pre", 1000);
    step();
    chk("multi_hot_step", 984);

    restart(4'b0001);
    run_to(600);
    options = 4'b1000;
    step();
    chk("rate_drop_nowrap", 1000);
    step();
    chk("rate_drop_step", 984);

    restart(4'b1000);
    run_to(3030);
    chk("g40", 625);
    #2 rst_n = 0;
    #1 chk("async_reset_y", 0);
    total++;
    if (dut.g === 7'd64) passed++;
    else $display("FAIL async_reset_g: g=%0d expected 64", dut.g);
    #1 rst_n = 1;
    step();
    chk("after_reset_unity", 1000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
